// File: rtl/gpio_pattern_seq.sv
// gpio_pattern_seq: prescaled GPIO/LED pattern sequencer with start/stop/pause/mode control
module gpio_pattern_seq #(
  parameter int unsigned DIV   = 12_500_000,
  parameter int unsigned DIV_W = 27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        pause,
  input  logic        mode_load,
  input  logic [1:0]  mode_in,
  output logic [7:0]  gpio,
  output logic        tick,
  output logic        busy,
  output logic [15:0] step_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);
  state_t           state_q;
  logic [1:0]       mode_q;
  logic             dir_q;
  logic             dir_d;
  logic [DIV_W-1:0] presc_q;
  logic [7:0]       gpio_q;
  logic [7:0]       gpio_d;
  logic [7:0]       bounce;
  logic             tick_q;
  logic             busy_q;
  logic [15:0]      cnt_q;
  function automatic logic [7:0] seed(input logic [1:0] m);
    return m == 2'd0 ? 8'h00 : m == 2'd3 ? 8'hff : 8'h01;
  endfunction
  // dir_q=0 shifts left; it flips as soon as the output lands on an end bit
  always_comb begin
    bounce = dir_q ? {1'b0, gpio_q[7:1]} : {gpio_q[6:0], 1'b0};
    gpio_d = mode_q == 2'd0 ? gpio_q + 8'd1 :
             mode_q == 2'd1 ? {gpio_q[6:0], gpio_q[7]} :
             mode_q == 2'd2 ? bounce : ~gpio_q;
    dir_d  = (mode_q == 2'd2 && (dir_q ? bounce == 8'h01 : bounce == 8'h80)) ? ~dir_q : dir_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 2'd0;
      dir_q   <= 1'b0;
      presc_q <= '0;
      gpio_q  <= 8'h00;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      tick_q <= 1'b0;
      if (stop) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        gpio_q  <= 8'h00;
        presc_q <= '0;
        cnt_q   <= 16'd0;
      end else if (mode_load) begin
        mode_q <= mode_in;
        if (state_q != IDLE) begin
          gpio_q  <= seed(mode_in);
          dir_q   <= 1'b0;
          presc_q <= '0;
          cnt_q   <= 16'd0;
        end
      end else if (start && state_q == IDLE) begin
        state_q <= RUN;
        busy_q  <= 1'b1;
        gpio_q  <= seed(mode_q);
        dir_q   <= 1'b0;
        presc_q <= '0;
        cnt_q   <= 16'd0;
      end else if (state_q != IDLE) begin
        if (pause) begin
          state_q <= PAUSE;
        end else begin
          state_q <= RUN;
          if (presc_q == LAST) begin
            presc_q <= '0;
            gpio_q  <= gpio_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_q + 16'd1;
            tick_q  <= 1'b1;
          end else begin
            presc_q <= presc_q + 1'b1;
          end
        end
      end
    end
  end
  assign gpio     = gpio_q;
  assign tick     = tick_q;
  assign busy     = busy_q;
  assign step_cnt = cnt_q;
endmodule
